// File: rtl/cpu32_pkg.sv
// rtl/cpu32_pkg.sv - shared constants, fetch state type and branch-target helper for the 32-bit CPU
package cpu32_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'hE1A0_0000;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam int          FILL_CYCLES       = 2;

  typedef enum logic {
    FILL,
    RUN
  } fetch_state_e;

  // The PC reads two words ahead of the branch, so the base is the branch address plus 8.
  function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [31:0] off);
    logic [31:0] sum;
    sum = base + 32'd8 + off;
    return {sum[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_pcgen.sv
// rtl/ifetch_pcgen.sv - next-PC selection (reset / hold / +4 / branch target) and target adder
module ifetch_pcgen
  import cpu32_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic        rst,
  input  logic        hold,
  input  logic        take_br,
  input  logic [31:0] pc,
  input  logic [31:0] iaddr_d,
  input  logic [31:0] bv,
  output logic [31:0] pc_next
);

  logic [31:0] target;

  assign target = branch_target(iaddr_d, bv);

  // A taken branch outranks a stall.
  always_comb begin
    pc_next = pc + 32'd4;
    if (rst) begin
      pc_next = RESET_VEC;
    end else if (take_br) begin
      pc_next = target;
    end else if (hold) begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/ifetch32.sv
// rtl/ifetch32.sv - instruction fetch unit: PC, imem interface, branch redirect and squash
// Optional branch-with-link write of r14 is enabled by defining IFETCH_LINK_EN.
module ifetch32
  import cpu32_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ib,
  input  logic [31:0] bv,
  input  logic        bl,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  output logic [31:0] iout,
  output logic [31:0] iaddr,
  output logic        ivalid,
  output logic        lr_we,
  output logic [31:0] lr_val
);

  fetch_state_e state;
  logic [1:0]   cnt;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  addr_q;
  logic [31:0]  iout_q;
  logic [31:0]  iaddr_q;
  logic [31:0]  iaddr_d;
  logic         valid_q;
  logic         take_br;
  logic         advance;
  logic         valid_next;

  assign take_br   = ib & (state == RUN);
  assign advance   = take_br | ~stall;
  assign imem_ren  = rst | advance;
  assign imem_addr = pc;
  assign iout      = iout_q;
  assign iaddr     = iaddr_q;
  assign ivalid    = valid_q & ~ib;

  ifetch_pcgen #(
    .RESET_VEC(RESET_VEC)
  ) u_pcgen (
    .rst    (rst),
    .hold   (stall),
    .take_br(take_br),
    .pc     (pc),
    .iaddr_d(iaddr_d),
    .bv     (bv),
    .pc_next(pc_next)
  );

  // The word being latched is on-path once the fill is about to complete.
  always_comb begin
    valid_next = 1'b0;
    if (take_br) begin
      valid_next = 1'b0;
    end else if (state == RUN) begin
      valid_next = 1'b1;
    end else begin
      valid_next = (cnt == 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_VEC;
      state   <= FILL;
      cnt     <= 2'(FILL_CYCLES);
      addr_q  <= 32'd0;
      iout_q  <= NOP_INSTR;
      iaddr_q <= 32'd0;
      iaddr_d <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc <= pc_next;
      if (advance) begin
        addr_q  <= pc;
        iaddr_q <= addr_q;
        iaddr_d <= iaddr_q;
        iout_q  <= valid_next ? imem_rdata : NOP_INSTR;
        valid_q <= valid_next;
        if (take_br) begin
          state <= FILL;
          cnt   <= 2'(FILL_CYCLES);
        end else if (state == FILL) begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= RUN;
          end
        end
      end
    end
  end

`ifdef IFETCH_LINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_we  <= 1'b0;
      lr_val <= 32'd0;
    end else begin
      lr_we <= take_br & bl;
      if (take_br & bl) begin
        lr_val <= iaddr_d + 32'd4;
      end
    end
  end
`else
  logic unused_bl;
  assign unused_bl = bl;
  assign lr_we     = 1'b0;
  assign lr_val    = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch32.sv
// tb/tb_ifetch32.sv - directed per-cycle vectors for ifetch32 with a behavioral instruction memory
module tb_ifetch32;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
`ifdef IFETCH_LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif
  localparam logic [31:0] LV1 = LINK ? 32'h44 : 32'h0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        ib;
    logic        bl;
    logic [31:0] bv;
    logic [31:0] e_addr;
    logic        e_ren;
    logic        e_valid;
    logic [31:0] e_iout;
    logic        ck_ia;
    logic [31:0] e_iaddr;
    logic        e_lrwe;
    logic [31:0] e_lrval;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, ib, bl;
  logic [31:0] bv;
  logic [31:0] imem_addr, imem_rdata, iout, iaddr, lr_val;
  logic        imem_ren, ivalid, lr_we;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ifetch32 dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .ib        (ib),
    .bv        (bv),
    .bl        (bl),
    .imem_addr (imem_addr),
    .imem_ren  (imem_ren),
    .imem_rdata(imem_rdata),
    .iout      (iout),
    .iaddr     (iaddr),
    .ivalid    (ivalid),
    .lr_we     (lr_we),
    .lr_val    (lr_val)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= mw(imem_addr);
  end

  function automatic vec_t mk(input logic r, s, b, l, input logic [31:0] off,
                              input logic [31:0] a, input logic ren, v, input logic [31:0] io,
                              input logic cia, input logic [31:0] ia, input logic we,
                              input logic [31:0] lv);
    vec_t x;
    x.rst = r; x.stall = s; x.ib = b; x.bl = l; x.bv = off;
    x.e_addr = a; x.e_ren = ren; x.e_valid = v; x.e_iout = io;
    x.ck_ia = cia; x.e_iaddr = ia; x.e_lrwe = we; x.e_lrval = lv;
    return x;
  endfunction

  function automatic vec_t run(input logic [31:0] a, input logic [31:0] ia, input logic [31:0] lv);
    return mk(0, 0, 0, 0, 0, a, 1, 1, mw(ia), 1, ia, 0, lv);
  endfunction

  function automatic vec_t bub(input logic [31:0] a, input logic [31:0] lv);
    return mk(0, 0, 0, 0, 0, a, 1, 0, NOP, 0, 0, 0, lv);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec %0d %s: got %h expected %h", n_vec, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; stall = v.stall; ib = v.ib; bl = v.bl; bv = v.bv;
    #1;
    chk("imem_addr", imem_addr, v.e_addr);
    chk("imem_ren", 32'(imem_ren), 32'(v.e_ren));
    chk("ivalid", 32'(ivalid), 32'(v.e_valid));
    chk("iout", iout, v.e_iout);
    if (v.ck_ia) chk("iaddr", iaddr, v.e_iaddr);
    chk("lr_we", 32'(lr_we), 32'(v.e_lrwe));
    chk("lr_val", lr_val, v.e_lrval);
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, sequential stream, two redirects (the second with link), ib during fill.
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 1, 0, NOP, 1, 32'h0, 0, 32'h0));
    tbl.push_back(bub(32'h4, 0));
    for (int k = 2; k <= 10; k++) tbl.push_back(run(32'(4 * k), 32'(4 * (k - 2)), 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h10, 32'h2C, 1, 0, mw(32'h24), 1, 32'h24, 0, 0));
    tbl.push_back(bub(32'h38, 0));
    tbl.push_back(bub(32'h3C, 0));
    tbl.push_back(run(32'h40, 32'h38, 0));
    tbl.push_back(run(32'h44, 32'h3C, 0));
    tbl.push_back(run(32'h48, 32'h40, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFF8, 32'h4C, 1, 0, mw(32'h44), 1, 32'h44, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h40, 1, 0, NOP, 0, 0, LINK, LV1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h100, 32'h44, 1, 0, NOP, 0, 0, 0, LV1));
    tbl.push_back(run(32'h48, 32'h40, LV1));
    tbl.push_back(run(32'h4C, 32'h44, LV1));
    tbl.push_back(run(32'h50, 32'h48, LV1));

    rst = 1; stall = 0; ib = 0; bl = 0; bv = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // Four-cycle stall mid-stream, then resume without lost or repeated addresses.
    for (int s = 0; s < 4; s++) apply(mk(0, 1, 0, 0, 0, 32'h54, 0, 1, mw(32'h4C), 1, 32'h4C, 0, LV1));
    apply(run(32'h54, 32'h4C, LV1));
    apply(run(32'h58, 32'h50, LV1));
    apply(run(32'h5C, 32'h54, LV1));

    // Stall together with ib: redirect to 0x54 + 8 + 0x20.
    apply(mk(0, 1, 1, 0, 32'h20, 32'h60, 1, 0, mw(32'h58), 1, 32'h58, 0, LV1));
    apply(bub(32'h7C, LV1));
    apply(bub(32'h80, LV1));
    apply(run(32'h84, 32'h7C, LV1));

    // Reset arriving with a branch-with-link: restart from the reset vector, no link write.
    apply(mk(1, 0, 1, 1, 32'h40, 32'h88, 1, 0, mw(32'h80), 1, 32'h80, 0, LV1));
    apply(mk(0, 0, 0, 0, 0, 32'h0, 1, 0, NOP, 1, 32'h0, 0, 32'h0));
    apply(bub(32'h4, 0));
    apply(run(32'h8, 32'h0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
